regfile_scoreboard: RTL and testbench

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

---
 rtl/regfile_scoreboard_if.sv | 33 +++
 rtl/regfile_scoreboard.sv | 80 ++++++++
 tb/tb_regfile_scoreboard.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// Register-file port bundle: writeback, issue and two read ports with their busy/stall results.
// master drives indices, strobes and data; slave is the register file returning read data and hazard status.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  ctrl_writeEnable;
    logic [4:0]            ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic                  ctrl_issueEnable;
    logic [4:0]            ctrl_issueReg;
    logic [4:0]            ctrl_readRegA;
    logic [4:0]            ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  busyA;
    logic                  busyB;
    logic                  stall;
    logic [5:0]            pending_count;

    modport master (
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output ctrl_issueEnable, ctrl_issueReg,
        output ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB, busyA, busyB, stall, pending_count
    );

    modport slave (
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  ctrl_issueEnable, ctrl_issueReg,
        input  ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB, busyA, busyB, stall, pending_count
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// 32-entry register file with a pending-producer scoreboard; reads, busy and stall are combinational (0 cycles),
// writes/issues/pending_count update on the clock edge; no backpressure -- stall is advisory to the issue stage.
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int BYPASS     = 1
) (
    input logic              clock,
    input logic              resetn,
    regfile_scoreboard_if.slave rf
);

    logic [DATA_WIDTH-1:0] regs [32];
    logic [31:0]           pend;
    logic [31:0]           pend_nxt;
    logic [5:0]            cnt;
    logic [5:0]            cnt_nxt;
    logic                  wr_vld;
    logic                  iss_vld;

    assign wr_vld  = rf.ctrl_writeEnable && (rf.ctrl_writeReg != 5'd0);
    assign iss_vld = rf.ctrl_issueEnable && (rf.ctrl_issueReg != 5'd0);

    // Issue is applied after the writeback clear so a new producer wins on a shared index.
    always_comb begin
        pend_nxt = pend;
        cnt_nxt  = '0;
        if (wr_vld)  pend_nxt[rf.ctrl_writeReg] = 1'b0;
        if (iss_vld) pend_nxt[rf.ctrl_issueReg] = 1'b1;
        pend_nxt[0] = 1'b0;
        for (int i = 0; i < 32; i++) begin
            cnt_nxt = cnt_nxt + {5'd0, pend_nxt[i]};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_vld) begin
            regs[rf.ctrl_writeReg] <= rf.data_writeReg;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_nxt;
            cnt  <= cnt_nxt;
        end
    end

    function automatic logic [DATA_WIDTH-1:0] rd_dat(input logic [4:0] idx);
        logic [DATA_WIDTH-1:0] d;
        d = '0;
        if (idx != 5'd0) begin
            if ((BYPASS != 0) && wr_vld && (rf.ctrl_writeReg == idx)) d = rf.data_writeReg;
            else                                                       d = regs[idx];
        end
        return d;
    endfunction

    // A same-cycle writeback resolves the hazard unless a new producer is issued to that index too.
    function automatic logic rd_busy(input logic [4:0] idx);
        logic fwd;
        fwd = (BYPASS != 0) && wr_vld && (rf.ctrl_writeReg == idx)
              && !(iss_vld && (rf.ctrl_issueReg == idx));
        return (idx != 5'd0) && pend[idx] && !fwd;
    endfunction

    assign rf.data_readRegA = rd_dat(rf.ctrl_readRegA);
    assign rf.data_readRegB = rd_dat(rf.ctrl_readRegB);
    assign rf.busyA         = rd_busy(rf.ctrl_readRegA);
    assign rf.busyB         = rd_busy(rf.ctrl_readRegB);
    assign rf.stall         = rf.busyA | rf.busyB;
    assign rf.pending_count = cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: expectations are queued as stimulus is driven and popped as outputs are sampled.
module tb_regfile_scoreboard;
    localparam int DW = 32;

    logic clock = 1'b0;
    logic resetn;

    regfile_scoreboard_if #(.DATA_WIDTH(DW)) rf ();

    regfile_scoreboard #(.DATA_WIDTH(DW), .BYPASS(1)) dut (
        .clock  (clock),
        .resetn (resetn),
        .rf     (rf)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    string       tag_q[$];
    logic [63:0] exp_q[$];

    task automatic sb_push(input string tag, input logic [63:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input logic [63:0] obs);
        string       t;
        logic [63:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=%0h expected=<none queued>", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e)
            else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", t, obs, e);
            end
        end
    endtask

    task automatic idle();
        rf.ctrl_writeEnable = 1'b0;
        rf.ctrl_writeReg    = 5'd0;
        rf.data_writeReg    = '0;
        rf.ctrl_issueEnable = 1'b0;
        rf.ctrl_issueReg    = 5'd0;
    endtask

    task automatic wr(input logic [4:0] r, input logic [DW-1:0] d);
        rf.ctrl_writeEnable = 1'b1;
        rf.ctrl_writeReg    = r;
        rf.data_writeReg    = d;
    endtask

    task automatic iss(input logic [4:0] r);
        rf.ctrl_issueEnable = 1'b1;
        rf.ctrl_issueReg    = r;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0;
        idle();
        rf.ctrl_readRegA = 5'd5;
        rf.ctrl_readRegB = 5'd0;
        #2;
        sb_push("rst_count", 0); sb_push("rst_stall", 0); sb_push("rst_rdA", 0);
        sb_check(rf.pending_count); sb_check(rf.stall); sb_check(rf.data_readRegA);
        tick(); tick();
        resetn = 1'b1;

        // write r5, bypass visible same cycle, stored value next cycle
        wr(5'd5, 32'hDEADBEEF);
        #1; sb_push("r5_bypass", 32'hDEADBEEF); sb_check(rf.data_readRegA);
        tick(); idle();
        #1; sb_push("r5_read", 32'hDEADBEEF); sb_push("r5_busyA", 0);
        sb_check(rf.data_readRegA); sb_check(rf.busyA);

        // r0 ignores writes and never forwards
        rf.ctrl_readRegA = 5'd0; rf.ctrl_readRegB = 5'd0;
        wr(5'd0, 32'h12345678);
        #1; sb_push("r0_nofwd", 0); sb_check(rf.data_readRegA);
        tick(); idle();
        #1;
        sb_push("r0_rdA", 0); sb_push("r0_rdB", 0); sb_push("r0_busyA", 0);
        sb_push("r0_busyB", 0); sb_push("r0_count", 0);
        sb_check(rf.data_readRegA); sb_check(rf.data_readRegB); sb_check(rf.busyA);
        sb_check(rf.busyB); sb_check(rf.pending_count);

        // issue r7, then resolve it by writeback with forwarding
        iss(5'd7);
        tick(); idle();
        rf.ctrl_readRegB = 5'd7;
        #1; sb_push("r7_busyB", 1); sb_push("r7_stall", 1); sb_push("r7_count", 1);
        sb_check(rf.busyB); sb_check(rf.stall); sb_check(rf.pending_count);
        wr(5'd7, 32'hA5A5A5A5);
        #1; sb_push("r7_fwd_busyB", 0); sb_push("r7_fwd_rdB", 32'hA5A5A5A5); sb_push("r7_fwd_stall", 0);
        sb_check(rf.busyB); sb_check(rf.data_readRegB); sb_check(rf.stall);
        tick(); idle();
        #1; sb_push("r7_after_count", 0); sb_push("r7_after_busyB", 0); sb_push("r7_after_rdB", 32'hA5A5A5A5);
        sb_check(rf.pending_count); sb_check(rf.busyB); sb_check(rf.data_readRegB);

        // r3 pending, then simultaneous issue + write: data lands, pend stays
        iss(5'd3);
        tick(); idle();
        rf.ctrl_readRegA = 5'd3;
        #1; sb_push("r3_count", 1); sb_push("r3_busyA", 1);
        sb_check(rf.pending_count); sb_check(rf.busyA);
        iss(5'd3); wr(5'd3, 32'h1);
        #1; sb_push("r3_same_busyA", 1); sb_push("r3_same_rdA", 32'h1);
        sb_check(rf.busyA); sb_check(rf.data_readRegA);
        tick(); idle();
        #1; sb_push("r3_after_rdA", 32'h1); sb_push("r3_after_busyA", 1); sb_push("r3_after_count", 1);
        sb_check(rf.data_readRegA); sb_check(rf.busyA); sb_check(rf.pending_count);
        wr(5'd3, 32'h1);
        tick(); idle();
        #1; sb_push("r3_clear_count", 0); sb_check(rf.pending_count);

        // fill every register, including re-issuing an already-pending one
        for (int i = 1; i < 32; i++) begin
            iss(5'(i));
            tick();
        end
        iss(5'd31);
        tick(); idle();
        #1; sb_push("fill_count", 31); sb_check(rf.pending_count);
        iss(5'd9); wr(5'd4, 32'h44);
        tick(); idle();
        rf.ctrl_readRegA = 5'd4; rf.ctrl_readRegB = 5'd9;
        #1; sb_push("r9r4_count", 30); sb_push("r4_busyA", 0); sb_push("r4_rdA", 32'h44); sb_push("r9_busyB", 1);
        sb_check(rf.pending_count); sb_check(rf.busyA); sb_check(rf.data_readRegA); sb_check(rf.busyB);
        wr(5'd4, 32'h45);
        tick(); idle();
        #1; sb_push("r4_nonpend_count", 30); sb_push("r4_nonpend_rdA", 32'h45);
        sb_check(rf.pending_count); sb_check(rf.data_readRegA);
        iss(5'd4); wr(5'd9, 32'h99);
        tick(); idle();
        #1; sb_push("swap_count", 30); sb_push("swap_busyA", 1); sb_push("swap_busyB", 0);
        sb_check(rf.pending_count); sb_check(rf.busyA); sb_check(rf.busyB);

        // r2 pending with data, then reset between edges
        iss(5'd2); wr(5'd2, 32'h55);
        tick(); idle();
        rf.ctrl_readRegA = 5'd2;
        #1; sb_push("r2_rdA", 32'h55); sb_push("r2_busyA", 1);
        sb_check(rf.data_readRegA); sb_check(rf.busyA);
        resetn = 1'b0;
        #1; sb_push("mrst_rdA", 0); sb_push("mrst_count", 0); sb_push("mrst_stall", 0); sb_push("mrst_busyA", 0);
        sb_check(rf.data_readRegA); sb_check(rf.pending_count); sb_check(rf.stall); sb_check(rf.busyA);
        iss(5'd2); wr(5'd2, 32'h77);
        tick(); idle();
        #1; sb_push("inrst_rdA", 0); sb_push("inrst_count", 0);
        sb_check(rf.data_readRegA); sb_check(rf.pending_count);
        resetn = 1'b1;
        tick();
        #1; sb_push("postrst_rdA", 0); sb_push("postrst_count", 0);
        sb_check(rf.data_readRegA); sb_check(rf.pending_count);
        wr(5'd2, 32'h66);
        tick(); idle();
        #1; sb_push("first_wr_rdA", 32'h66); sb_check(rf.data_readRegA);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
